sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge_pkg.sv | 23 ++
 rtl/sram_axi_bridge_rr_arbiter.sv | 63 ++++++
 rtl/sram_axi_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings for sram_axi_bridge: read/write FSM states and AXI constants.
package bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AWW  = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_rr_arbiter.sv
// One-hot request arbiter; round-robin when SRAM_AXI_BRIDGE_RR_ARB_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] grant_o,
    input  logic              advance_i
);

`ifdef SRAM_AXI_BRIDGE_RR_ARB_EN
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    // Search starts at the pointer; the pointer moves past the winner only on acceptance.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr_q) + k) % NUM_CH;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
                if (advance_i) begin
                    ptr_d = PTR_W'((idx + 1) % NUM_CH);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic found;
    logic unused_ok;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req_i[k]) begin
                grant_o[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign unused_ok = ^{clk, reset, advance_i};
`endif

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges NUM_CH SRAM-like channels onto one AXI4 master with independent read and
// write paths. Optional round-robin arbitration: define SRAM_AXI_BRIDGE_RR_ARB_EN.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_wr,
    input  logic [2*NUM_CH-1:0]          ch_size,
    input  logic [ADDR_W*NUM_CH-1:0]     ch_addr,
    input  logic [DATA_W*NUM_CH-1:0]     ch_wdata,
    input  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb,
    output logic [NUM_CH-1:0]            ch_addr_ok,
    output logic [NUM_CH-1:0]            ch_data_ok,
    output logic [DATA_W-1:0]            ch_rdata,

    output logic [ID_W-1:0]              arid,
    output logic [ADDR_W-1:0]            araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arlock,
    output logic [3:0]                   arcache,
    output logic [2:0]                   arprot,
    output logic [3:0]                   arqos,
    output logic                         arvalid,
    input  logic                         arready,

    input  logic [ID_W-1:0]              rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,

    output logic [ID_W-1:0]              awid,
    output logic [ADDR_W-1:0]            awaddr,
    output logic [7:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         awlock,
    output logic [3:0]                   awcache,
    output logic [2:0]                   awprot,
    output logic [3:0]                   awqos,
    output logic                         awvalid,
    input  logic                         awready,

    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,

    input  logic [ID_W-1:0]              bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    rd_state_e           rd_state_q, rd_state_d;
    wr_state_e           wr_state_q, wr_state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;

    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [1:0]          rd_size_q, wr_size_q;
    logic [IDX_W-1:0]    rd_owner_q, wr_owner_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [STRB_W-1:0]   wr_strb_q;

    logic [NUM_CH-1:0]   rd_req, wr_req, rd_gnt, wr_gnt;
    logic [IDX_W-1:0]    rd_gnt_idx, wr_gnt_idx;
    logic                rd_accept, wr_accept;
    logic                unused_ok;

    // A read hitting the word of an in-flight write is held off until that write retires.
    always_comb begin
        rd_req = '0;
        wr_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_req[i] = ch_req[i] & ch_wr[i];
            rd_req[i] = ch_req[i] & ~ch_wr[i] &
                        ~((wr_state_q != W_IDLE) &&
                          (ch_addr[i*ADDR_W+2 +: ADDR_W-2] == wr_addr_q[ADDR_W-1:2]));
        end
    end

    assign rd_accept = (rd_state_q == R_IDLE) && (|rd_req);
    assign wr_accept = (wr_state_q == W_IDLE) && (|wr_req);

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rd_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (rd_req),
        .grant_o   (rd_gnt),
        .advance_i (rd_accept)
    );

    rr_arbiter #(.NUM_CH(NUM_CH)) u_wr_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (wr_req),
        .grant_o   (wr_gnt),
        .advance_i (wr_accept)
    );

    always_comb begin
        rd_gnt_idx = '0;
        wr_gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_gnt[i]) rd_gnt_idx = IDX_W'(i);
            if (wr_gnt[i]) wr_gnt_idx = IDX_W'(i);
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (rd_accept) rd_state_d = R_AR;
            R_AR:    if (arready)   rd_state_d = R_R;
            R_R:     if (rvalid)    rd_state_d = R_IDLE;
            default:                rd_state_d = R_IDLE;
        endcase
    end

    // AW and W retire independently; B is entered only once neither is still pending.
    always_comb begin
        wr_state_d = wr_state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    wr_state_d = W_AWW;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                end
            end
            W_AWW: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) wr_state_d = W_B;
            end
            W_B: begin
                if (bvalid) wr_state_d = W_IDLE;
            end
            default: begin
                wr_state_d = W_IDLE;
                awvalid_d  = 1'b0;
                wvalid_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        if (rd_state_q == R_IDLE) ch_addr_ok = ch_addr_ok | rd_gnt;
        if (wr_state_q == W_IDLE) ch_addr_ok = ch_addr_ok | wr_gnt;
        if ((rd_state_q == R_R) && rvalid) ch_data_ok[rd_owner_q] = 1'b1;
        if ((wr_state_q == W_B) && bvalid) ch_data_ok[wr_owner_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_accept) begin
            rd_addr_q  <= ch_addr[rd_gnt_idx*ADDR_W +: ADDR_W];
            rd_size_q  <= ch_size[rd_gnt_idx*2 +: 2];
            rd_owner_q <= rd_gnt_idx;
        end
        if (wr_accept) begin
            wr_addr_q  <= ch_addr[wr_gnt_idx*ADDR_W +: ADDR_W];
            wr_size_q  <= ch_size[wr_gnt_idx*2 +: 2];
            wr_data_q  <= ch_wdata[wr_gnt_idx*DATA_W +: DATA_W];
            wr_strb_q  <= ch_wstrb[wr_gnt_idx*STRB_W +: STRB_W];
            wr_owner_q <= wr_gnt_idx;
        end
    end

    assign ch_rdata = rdata;

    assign arid    = ID_W'(rd_owner_q);
    assign araddr  = rd_addr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = size_to_axsize(rd_size_q);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arqos   = 4'd0;
    assign arvalid = (rd_state_q == R_AR);
    assign rready  = (rd_state_q == R_R);

    assign awid    = ID_W'(wr_owner_q);
    assign awaddr  = wr_addr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = size_to_axsize(wr_size_q);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awqos   = 4'd0;
    assign awvalid = awvalid_q;
    assign wdata   = wr_data_q;
    assign wstrb   = wr_strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = (wr_state_q == W_B);

    assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge with a hand-driven AXI slave.
module tb_sram_axi_bridge;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic                         clk;
    logic                         reset;
    logic [NUM_CH-1:0]            ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [2*NUM_CH-1:0]          ch_size;
    logic [ADDR_W*NUM_CH-1:0]     ch_addr;
    logic [DATA_W*NUM_CH-1:0]     ch_wdata;
    logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb;
    logic [DATA_W-1:0]            ch_rdata;

    logic [ID_W-1:0]   arid, awid, rid, bid;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [7:0]        arlen, awlen;
    logic [2:0]        arsize, awsize, arprot, awprot;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic              arlock, awlock, arvalid, arready, awvalid, awready;
    logic [3:0]        arcache, awcache, arqos, awqos;
    logic [DATA_W-1:0] rdata, wdata;
    logic [3:0]        wstrb;
    logic              rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    sram_axi_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_addr_ok(ch_addr_ok),
        .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_CH-1:0] exp_gnt;
        logic [ID_W-1:0]   exp_id;
        logic [2:0]        exp_sz;

        reset = 1'b1;
        ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0; ch_wstrb = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        cyc(); cyc();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid",  wvalid,  0);
        chk("rst_rready",  rready,  0);
        chk("rst_bready",  bready,  0);
        chk("rst_addr_ok", ch_addr_ok, 0);
        chk("rst_data_ok", ch_data_ok, 0);
        reset = 1'b0;
        cyc();

        // Zero-wait read on ch0: addr_ok at 0, arvalid at 1, data_ok at 2.
        ch_req = 2'b01; ch_wr = 2'b00; ch_size = {2'd0, 2'd2};
        ch_addr = {32'h0, 32'h1FC0_0000};
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h3C1D_0001;
        #1;
        chk("t1_addr_ok_c0", ch_addr_ok, 2'b01);
        chk("t1_data_ok_c0", ch_data_ok, 2'b00);
        chk("t1_arvalid_c0", arvalid, 0);
        cyc();
        ch_req = 2'b00;
        #1;
        chk("t1_arvalid_c1", arvalid, 1);
        chk("t1_araddr",     araddr, 32'h1FC0_0000);
        chk("t1_arsize",     arsize, 3'd2);
        chk("t1_arlen",      arlen, 8'd0);
        chk("t1_arburst",    arburst, 2'b01);
        chk("t1_arid",       arid, 4'd0);
        chk("t1_data_ok_c1", ch_data_ok, 2'b00);
        cyc();
        chk("t1_rready_c2",  rready, 1);
        chk("t1_data_ok_c2", ch_data_ok, 2'b01);
        chk("t1_rdata",      ch_rdata, 32'h3C1D_0001);
        cyc();
        arready = 1'b0; rvalid = 1'b0;
        #1;
        chk("t1_rready_c3",  rready, 0);
        chk("t1_data_ok_c3", ch_data_ok, 2'b00);

        // Concurrent ch0 read and ch1 write.
        ch_req = 2'b11; ch_wr = 2'b10; ch_size = {2'd2, 2'd2};
        ch_addr = {32'h0000_0080, 32'h0000_0040};
        ch_wdata = {32'hDEAD_BEEF, 32'h0}; ch_wstrb = {4'hF, 4'h0};
        #1;
        chk("t2_addr_ok", ch_addr_ok, 2'b11);
        cyc();
        ch_req = 2'b00;
        #1;
        chk("t2_arvalid", arvalid, 1);
        chk("t2_arid",    arid, 4'd0);
        chk("t2_awvalid", awvalid, 1);
        chk("t2_awid",    awid, 4'd1);
        chk("t2_awaddr",  awaddr, 32'h80);
        chk("t2_wvalid",  wvalid, 1);
        chk("t2_wdata",   wdata, 32'hDEAD_BEEF);
        chk("t2_wstrb",   wstrb, 4'hF);
        chk("t2_wlast",   wlast, 1);
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        cyc();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678; bvalid = 1'b1;
        #1;
        chk("t2_data_ok", ch_data_ok, 2'b11);
        chk("t2_rdata",   ch_rdata, 32'h1234_5678);
        cyc();
        rvalid = 1'b0; bvalid = 1'b0;
        #1;
        chk("t2_data_ok_after", ch_data_ok, 2'b00);

        // RAW hazard: ch1 write 0x100 then ch0 read 0x100 held until write retires.
        ch_req = 2'b10; ch_wr = 2'b10; ch_addr = {32'h0000_0100, 32'h0};
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("t3_wr_addr_ok", ch_addr_ok, 2'b10);
        cyc();
        ch_req = 2'b01; ch_wr = 2'b10; ch_addr = {32'h0, 32'h0000_0100};
        #1;
        chk("t3_raw_aww", ch_addr_ok, 2'b00);
        cyc();
        awready = 1'b0; wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_raw_b_wait", ch_addr_ok, 2'b00);
            chk("t3_no_data_ok", ch_data_ok, 2'b00);
            cyc();
        end
        bvalid = 1'b1;
        #1;
        chk("t3_b_data_ok",   ch_data_ok, 2'b10);
        chk("t3_raw_at_bval", ch_addr_ok, 2'b00);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("t3_read_granted", ch_addr_ok, 2'b01);
        cyc();
        ch_req = 2'b00; arready = 1'b1;
        #1;
        chk("t3_araddr", araddr, 32'h100);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        #1;
        chk("t3_rd_data_ok", ch_data_ok, 2'b01);
        chk("t3_rdata",      ch_rdata, 32'hCAFE_F00D);
        cyc();
        rvalid = 1'b0;

        // awready three cycles ahead of wready.
        ch_req = 2'b10; ch_wr = 2'b10; ch_addr = {32'h0000_0200, 32'h0};
        ch_wdata = {32'h0BAD_F00D, 32'h0}; ch_wstrb = {4'h3, 4'h0}; ch_size = {2'd1, 2'd2};
        #1;
        chk("t4_addr_ok", ch_addr_ok, 2'b10);
        cyc();
        ch_req = 2'b00; awready = 1'b1;
        #1;
        chk("t4_both_valid", {awvalid, wvalid}, 2'b11);
        chk("t4_awsize",     awsize, 3'd1);
        cyc();
        awready = 1'b0;
        #1;
        chk("t4_aw_dropped", {awvalid, wvalid}, 2'b01);
        chk("t4_no_bready",  bready, 0);
        cyc();
        chk("t4_w_hold2", wvalid, 1);
        cyc();
        wready = 1'b1;
        #1;
        chk("t4_w_hold3",   wvalid, 1);
        chk("t4_wdata",     wdata, 32'h0BAD_F00D);
        cyc();
        wready = 1'b0;
        #1;
        chk("t4_w_dropped", wvalid, 0);
        chk("t4_bready",    bready, 1);
        chk("t4_no_early",  ch_data_ok, 2'b00);
        bvalid = 1'b1;
        #1;
        chk("t4_data_ok",   ch_data_ok, 2'b10);
        cyc();
        bvalid = 1'b0;
        #1;
        chk("t4_single",    ch_data_ok, 2'b00);

        // Two channels reading continuously.
        ch_req = 2'b11; ch_wr = 2'b00; ch_size = {2'd1, 2'd0};
        ch_addr = {32'h0000_2000, 32'h0000_1000};
        arready = 1'b1; rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_AXI_BRIDGE_RR_ARB_EN
            exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b01;
`endif
            exp_id = exp_gnt[1] ? 4'd1 : 4'd0;
            exp_sz = exp_gnt[1] ? 3'd1 : 3'd0;
            #1;
            chk("t5_grant", ch_addr_ok, exp_gnt);
            cyc();
            chk("t5_busy_stall", ch_addr_ok, 2'b00);
            chk("t5_arid",       arid, exp_id);
            chk("t5_arsize",     arsize, exp_sz);
            cyc();
            chk("t5_data_ok",    ch_data_ok, exp_gnt);
            cyc();
        end
        ch_req = 2'b00; arready = 1'b0; rvalid = 1'b0;

        // Reset while a read sits in R with rvalid pending.
        ch_req = 2'b01; ch_addr = {32'h0, 32'h0000_0300}; arready = 1'b1;
        #1;
        chk("t6_addr_ok", ch_addr_ok, 2'b01);
        cyc();
        ch_req = 2'b00;
        cyc();
        arready = 1'b0;
        #1;
        chk("t6_rready_before", rready, 1);
        reset = 1'b1; rvalid = 1'b1;
        #1;
        chk("t6_rst_rready",  rready, 0);
        chk("t6_rst_data_ok", ch_data_ok, 2'b00);
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_valids",      {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        chk("t6_no_data_ok",  ch_data_ok, 2'b00);
        rvalid = 1'b0; ch_req = 2'b01;
        #1;
        chk("t6_idle_accept", ch_addr_ok, 2'b01);
        cyc();
        ch_req = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
